// File: rtl/fifo_uart_tx_amisha_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg_amisha
// Shared definitions for the UART transmit path and its future receiver twin:
//   - FSM state encodings (IDLE, START, DATA, PARITY, STOP)
//   - OVERSAMPLE: baud ticks per serial bit
// Build option: UART_TX_PARITY_EN (PARITY state used only when defined).
// -----------------------------------------------------------------------------
package uart_pkg_amisha;

   // Baud ticks per bit (16x oversampling)
   localparam int OVERSAMPLE = 16;

   // State encodings, kept as named constants so a receiver can share them
   localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
   localparam logic [2:0] ST_START_ENC  = 3'd1;
   localparam logic [2:0] ST_DATA_ENC   = 3'd2;
   localparam logic [2:0] ST_PARITY_ENC = 3'd3;
   localparam logic [2:0] ST_STOP_ENC   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_START  = ST_START_ENC,
      ST_DATA   = ST_DATA_ENC,
      ST_PARITY = ST_PARITY_ENC,
      ST_STOP   = ST_STOP_ENC
   } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_amisha_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_amisha_if
// Read-side handshake between a synchronous FIFO and its consumer.
//   fifo_empty_amisha   : FIFO empty flag (FIFO -> consumer)
//   fifo_r_data_amisha  : FIFO head word, valid while not empty (FIFO -> consumer)
//   fifo_rd_amisha      : one-cycle pop strobe (consumer -> FIFO)
// Modports: master = consumer (UART transmitter), slave = FIFO.
// -----------------------------------------------------------------------------
interface fifo_uart_tx_amisha_if #(
   parameter int DBIT_amisha = 8
) ();

   logic                   fifo_empty_amisha;
   logic [DBIT_amisha-1:0] fifo_r_data_amisha;
   logic                   fifo_rd_amisha;

   modport master (
      input  fifo_empty_amisha,
      input  fifo_r_data_amisha,
      output fifo_rd_amisha
   );

   modport slave (
      output fifo_empty_amisha,
      output fifo_r_data_amisha,
      input  fifo_rd_amisha
   );

endinterface

// File: rtl/fifo_uart_tx_amisha_baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen_amisha
// Mod-DVSR counter producing a one-cycle tick when the count equals DVSR-1.
// A synchronous clear restarts the count at 0 so a frame can align its first
// bit to the clear. Shared with the future receiver.
// Ports:
//   clk_amisha      in  clock
//   reset_n_amisha  in  asynchronous active-low reset
//   clr_amisha      in  synchronous clear of the divider
//   tick_amisha     out baud tick (high for one clock every DVSR clocks)
// -----------------------------------------------------------------------------
module baud_gen_amisha #(
   parameter int DVSR_amisha = 163
) (
   input  logic clk_amisha,
   input  logic reset_n_amisha,
   input  logic clr_amisha,
   output logic tick_amisha
);

   localparam int               DIV_W    = (DVSR_amisha > 1) ? $clog2(DVSR_amisha) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DVSR_amisha - 1);

   logic [DIV_W-1:0] count_r;

   // Divider: counts 0..DVSR-1 and wraps explicitly; clear has priority
   always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
      if (!reset_n_amisha) begin
         count_r <= {DIV_W{1'b0}};
      end else if (clr_amisha) begin
         count_r <= {DIV_W{1'b0}};
      end else if (count_r == DIV_LAST) begin
         count_r <= {DIV_W{1'b0}};
      end else begin
         count_r <= count_r + DIV_W'(1);
      end
   end

   // Tick decode on the terminal count
   always_comb begin
      tick_amisha = 1'b0;
      if (count_r == DIV_LAST) begin
         tick_amisha = 1'b1;
      end else begin
         tick_amisha = 1'b0;
      end
   end

endmodule

// File: rtl/fifo_uart_tx_amisha.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_amisha
// FIFO-draining UART transmitter. While the FIFO is non-empty it pops one word
// (combinational pop strobe in IDLE) and sends it as an asynchronous frame:
// start bit, DBIT data bits LSB first, optional even parity, stop bit(s).
// Build option: define UART_TX_PARITY_EN to add the even-parity bit.
// Ports:
//   clk_amisha      in  clock, rising edge
//   reset_n_amisha  in  asynchronous active-low reset
//   fifo            fifo_uart_tx_amisha_if.master (empty, head data, pop strobe)
//   tx_amisha       out serial line, idle high (registered)
//   tx_busy_amisha  out high while a frame is in progress (registered)
// -----------------------------------------------------------------------------
module fifo_uart_tx_amisha
   import uart_pkg_amisha::*;
#(
   parameter int DBIT_amisha    = 8,
   parameter int SB_TICK_amisha = 16,
   parameter int DVSR_amisha    = 163
) (
   input  logic                         clk_amisha,
   input  logic                         reset_n_amisha,
   fifo_uart_tx_amisha_if.master        fifo,
   output logic                         tx_amisha,
   output logic                         tx_busy_amisha
);

   localparam int               BIT_W     = (DBIT_amisha > 1) ? $clog2(DBIT_amisha) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DBIT_amisha - 1);
   localparam logic [4:0]       LAST_OS   = 5'(OVERSAMPLE - 1);
   localparam logic [4:0]       LAST_STOP = 5'(SB_TICK_amisha - 1);

   tx_state_e              state_r;
   logic [4:0]             tick_cnt_r;
   logic [BIT_W-1:0]       bit_cnt_r;
   logic [DBIT_amisha-1:0] shift_r;
   logic [DBIT_amisha-1:0] shift_next_s;
   logic                   tx_r;
   logic                   busy_r;
   logic                   pop_s;
   logic                   tick_s;
`ifdef UART_TX_PARITY_EN
   logic                   parity_r;

   // Even parity of a data word: the bit that makes the total count of ones even
   function automatic logic even_parity_f(input logic [DBIT_amisha-1:0] word);
      even_parity_f = ^word;
   endfunction
`endif

   // Pop strobe: only from IDLE with data available; held low during reset so
   // the FIFO is never drained while the transmitter is inactive
   always_comb begin
      pop_s = 1'b0;
      if (reset_n_amisha && (state_r == ST_IDLE) && !fifo.fifo_empty_amisha) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   assign fifo.fifo_rd_amisha = pop_s;

   // Next shift-register value, used to present the following data bit
   always_comb begin
      shift_next_s = shift_r >> 1'b1;
   end

   // Baud tick source, restarted at every pop so bit cells align to the frame
   baud_gen_amisha #(
      .DVSR_amisha (DVSR_amisha)
   ) u_baud_gen (
      .clk_amisha     (clk_amisha),
      .reset_n_amisha (reset_n_amisha),
      .clr_amisha     (pop_s),
      .tick_amisha    (tick_s)
   );

   // Transmit FSM; tx and busy are loaded with the level of the state being
   // entered so they stay registered without a cycle of lag
   always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
      if (!reset_n_amisha) begin
         state_r    <= ST_IDLE;
         tick_cnt_r <= 5'd0;
         bit_cnt_r  <= {BIT_W{1'b0}};
         shift_r    <= {DBIT_amisha{1'b0}};
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               tx_r   <= 1'b1;
               busy_r <= 1'b0;
               if (pop_s) begin
                  // Word is captured here; later FIFO activity cannot affect it
                  shift_r    <= fifo.fifo_r_data_amisha;
`ifdef UART_TX_PARITY_EN
                  parity_r   <= even_parity_f(fifo.fifo_r_data_amisha);
`endif
                  tick_cnt_r <= 5'd0;
                  bit_cnt_r  <= {BIT_W{1'b0}};
                  state_r    <= ST_START;
                  tx_r       <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end

            ST_START: begin
               if (tick_s) begin
                  if (tick_cnt_r == LAST_OS) begin
                     tick_cnt_r <= 5'd0;
                     bit_cnt_r  <= {BIT_W{1'b0}};
                     state_r    <= ST_DATA;
                     tx_r       <= shift_r[0];
                  end else begin
                     tick_cnt_r <= tick_cnt_r + 5'd1;
                  end
               end
            end

            ST_DATA: begin
               if (tick_s) begin
                  if (tick_cnt_r == LAST_OS) begin
                     tick_cnt_r <= 5'd0;
                     shift_r    <= shift_next_s;
                     if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_r <= {BIT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
                        state_r   <= ST_PARITY;
                        tx_r      <= parity_r;
`else
                        state_r   <= ST_STOP;
                        tx_r      <= 1'b1;
`endif
                     end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        tx_r      <= shift_next_s[0];
                     end
                  end else begin
                     tick_cnt_r <= tick_cnt_r + 5'd1;
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (tick_s) begin
                  if (tick_cnt_r == LAST_OS) begin
                     tick_cnt_r <= 5'd0;
                     state_r    <= ST_STOP;
                     tx_r       <= 1'b1;
                  end else begin
                     tick_cnt_r <= tick_cnt_r + 5'd1;
                  end
               end
            end
`endif

            ST_STOP: begin
               tx_r <= 1'b1;
               if (tick_s) begin
                  if (tick_cnt_r == LAST_STOP) begin
                     // Return to IDLE guarantees at least one idle-high cycle
                     tick_cnt_r <= 5'd0;
                     state_r    <= ST_IDLE;
                     busy_r     <= 1'b0;
                  end else begin
                     tick_cnt_r <= tick_cnt_r + 5'd1;
                  end
               end
            end

            default: begin
               state_r    <= ST_IDLE;
               tick_cnt_r <= 5'd0;
               bit_cnt_r  <= {BIT_W{1'b0}};
               tx_r       <= 1'b1;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign tx_amisha      = tx_r;
   assign tx_busy_amisha = busy_r;

endmodule
